dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache for the MEM stage.
- Serves load/store requests from EX/MEM.
- Returns load data to the MEM/WB register through `rdata`.
- Raises `dcache_stall`, which freezes the pipeline registers while a miss is serviced.
- Talks to backing memory one word per handshake.

---
 rtl/dcache_ctrl_pkg.sv | 23 ++
 rtl/dcache_data_array.sv | 34 +++
 rtl/dcache_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared types, defaults and address-field helpers for the data cache
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBACK  = 2'd1,
    REFILL = 2'd2
  } dcache_state_t;

  localparam int DCACHE_LINES  = 64;
  localparam int DCACHE_WORDS  = 4;
  localparam int DCACHE_ADDR_W = 32;

  // Byte address layout, low to high: byte lane (2), word offset, index, tag.
  function automatic int idx_lsb(input int words);
    return 2 + $clog2(words);
  endfunction

  function automatic int tag_lsb(input int lines, input int words);
    return idx_lsb(words) + $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// rtl/dcache_data_array.sv - LINES x WORDS x 32 data storage
// Asynchronous read port, one synchronous byte-masked write port.
module dcache_data_array
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = DCACHE_LINES,
  parameter int WORDS = DCACHE_WORDS,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_word,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_word,
  input  logic [3:0]       wr_strb,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [LINES*WORDS];

  assign rd_data = mem[{rd_idx, rd_word}];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[{wr_idx, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
// Tags, valid/dirty bits and the miss FSM live here; line data lives in dcache_data_array.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES  = DCACHE_LINES,
  parameter int WORDS  = DCACHE_WORDS,
  parameter int ADDR_W = DCACHE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic [31:0]       rdata,
  output logic              dcache_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int IDX_LSB = idx_lsb(WORDS);
  localparam int TAG_LSB = tag_lsb(LINES, WORDS);
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

  dcache_state_t state, state_nxt;
  logic [OFF_W-1:0] cnt, cnt_inc;
  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [LINES];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req, hit, ack, last, fill_done, unused_lsbs;

  logic             arr_we;
  logic [OFF_W-1:0] arr_word, arr_rd_word;
  logic [3:0]       arr_strb;
  logic [31:0]      arr_wdata, arr_rdata;

  assign off         = addr[IDX_LSB-1:2];
  assign idx         = addr[TAG_LSB-1:IDX_LSB];
  assign tag         = addr[ADDR_W-1:TAG_LSB];
  assign unused_lsbs = ^addr[1:0];

  assign req       = rd_en | wr_en;
  assign hit       = req & valid[idx] & (tags[idx] == tag);
  assign ack       = mem_req & mem_ack;
  assign last      = (cnt == LAST);
  assign cnt_inc   = cnt + OFF_W'(1);
  assign fill_done = (state == REFILL) & ack & last;
  assign rdata     = arr_rdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && !hit) state_nxt = (valid[idx] && dirty[idx]) ? WBACK : REFILL;
      WBACK:   if (ack && last) state_nxt = REFILL;
      REFILL:  if (ack && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The single read port serves loads in IDLE and pre-fetches the next victim word otherwise.
  always_comb begin
    dcache_stall = req & ((state != IDLE) | ~hit);
    arr_we       = 1'b0;
    arr_word     = off;
    arr_strb     = wstrb;
    arr_wdata    = wdata;
    arr_rd_word  = off;
    case (state)
      IDLE: begin
        arr_we = wr_en & hit;
        if (!hit) arr_rd_word = '0;
      end
      WBACK: arr_rd_word = cnt_inc;
      REFILL: begin
        arr_we    = ack;
        arr_word  = cnt;
        arr_strb  = 4'hF;
        arr_wdata = mem_rdata;
      end
      default: arr_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      dirty     <= '0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (wr_en) dirty[idx] <= 1'b1;
          end else if (req) begin
            cnt     <= '0;
            mem_req <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tags[idx], idx, {OFF_W{1'b0}}, 2'b00};
              mem_wdata <= arr_rdata;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {tag, idx, {OFF_W{1'b0}}, 2'b00};
            end
          end
        end
        WBACK: begin
          if (ack) begin
            cnt <= cnt_inc;
            if (last) begin
              mem_we   <= 1'b0;
              mem_addr <= {tag, idx, {OFF_W{1'b0}}, 2'b00};
            end else begin
              mem_addr  <= {tags[idx], idx, cnt_inc, 2'b00};
              mem_wdata <= arr_rdata;
            end
          end
        end
        REFILL: begin
          if (ack) begin
            cnt <= cnt_inc;
            if (last) begin
              mem_req    <= 1'b0;
              valid[idx] <= 1'b1;
              dirty[idx] <= 1'b0;
            end else begin
              mem_addr <= {tag, idx, cnt_inc, 2'b00};
            end
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) tags[idx] <= tag;
  end

  dcache_data_array #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_data (
    .clk    (clk),
    .rd_idx (idx),
    .rd_word(arr_rd_word),
    .rd_data(arr_rdata),
    .wr_en  (arr_we),
    .wr_idx (idx),
    .wr_word(arr_word),
    .wr_strb(arr_strb),
    .wr_data(arr_wdata)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
// Reference: word-level memory image plus per-index valid/tag/dirty bookkeeping.
module tb_dcache_ctrl;

  localparam int LINES = 64;
  localparam int WORDS = 4;

  logic        clk, rst, rd_en, wr_en;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        dcache_stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dcache_ctrl #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .dcache_stall(dcache_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    bit          we;
    int unsigned addr;
    int unsigned data;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  int unsigned bmem[int unsigned];
  int unsigned arch[int unsigned];
  bit          m_valid[LINES];
  bit          m_dirty[LINES];
  int unsigned m_tag[LINES];
  int          total, bad, max_gap, gap_left;
  bit          p_v, p_we;
  int unsigned p_addr, p_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned mem_val(int unsigned a);
    if (bmem.exists(a)) return bmem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int unsigned arch_val(int unsigned a);
    if (arch.exists(a)) return arch[a];
    return mem_val(a);
  endfunction

  function automatic int unsigned merge(int unsigned old, int unsigned d, bit [3:0] s);
    int unsigned m;
    m = 0;
    for (int b = 0; b < 4; b++) if (s[b]) m |= 32'hFF << (8 * b);
    return (old & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    arch.delete();
  endtask

  // Backing memory: acks after a random gap, checks the request is held until acked.
  initial begin
    mem_ack = 0; mem_rdata = 0; gap_left = 0; p_v = 0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      if (rst || !mem_req) begin
        p_v = 0;
        gap_left = 0;
      end else begin
        if (p_v) begin
          total++;
          if (mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wdata) begin
            bad++;
            $display("FAIL mem_hold: got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, p_we, p_addr, p_wdata);
          end
        end
        if (gap_left == 0) begin
          mem_ack = 1;
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else        mem_rdata = mem_val(mem_addr);
          log_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
          p_v = 0;
          gap_left = $urandom_range(0, max_gap);
        end else begin
          gap_left--;
          p_v = 1; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
        end
      end
    end
  end

  task automatic do_access(input bit rd, input bit wr, input int unsigned a,
                           input int unsigned d, input bit [3:0] s, input string nm);
    int unsigned wa, ix, tg, vaddr, exp_rd;
    bit          miss, vdirty;
    int          exp_cycles, cycles, n;
    txn_t        t;
    wa     = a & ~32'h3;
    ix     = (wa >> 4) % LINES;
    tg     = wa >> 10;
    miss   = !(m_valid[ix] && m_tag[ix] == tg);
    vdirty = miss && m_valid[ix] && m_dirty[ix];
    exp_q.delete();
    if (vdirty) begin
      for (int k = 0; k < WORDS; k++) begin
        vaddr = (m_tag[ix] << 10) | (ix << 4) | (k << 2);
        t = '{1'b1, vaddr, arch_val(vaddr)};
        exp_q.push_back(t);
      end
    end
    if (miss) begin
      for (int k = 0; k < WORDS; k++) begin
        t = '{1'b0, (wa & ~32'hF) + 4 * k, 0};
        exp_q.push_back(t);
      end
    end
    exp_cycles = !miss ? 0 : (vdirty ? 2 * WORDS + 1 : WORDS + 1);
    exp_rd     = arch_val(wa);

    @(negedge clk);
    rd_en = rd; wr_en = wr; addr = a; wdata = d; wstrb = s;
    log_q.delete();
    #1;
    total++;
    if (dcache_stall !== miss) begin
      bad++;
      $display("FAIL %s stall_req @%h: got %0b want %0b", nm, a, dcache_stall, miss);
    end
    cycles = 0;
    while (dcache_stall === 1'b1 && cycles < 400) begin
      @(negedge clk); #1;
      cycles++;
    end
    total++;
    if (cycles >= 400) begin
      bad++;
      $display("FAIL %s timeout @%h: stall still high after %0d cycles", nm, a, cycles);
    end
    if (max_gap == 0) begin
      total++;
      if (cycles != exp_cycles) begin
        bad++;
        $display("FAIL %s penalty @%h: got %0d want %0d", nm, a, cycles, exp_cycles);
      end
    end
    if (rd && !wr) begin
      total++;
      if (rdata !== exp_rd) begin
        bad++;
        $display("FAIL %s rdata @%h: got %h want %h", nm, a, rdata, exp_rd);
      end
    end
    @(posedge clk); #1;
    rd_en = 0; wr_en = 0;

    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s mem_count @%h: got %0d want %0d", nm, a, log_q.size(), exp_q.size());
    end
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      total++;
      if (log_q[k].we != exp_q[k].we || log_q[k].addr != exp_q[k].addr ||
          (exp_q[k].we && log_q[k].data != exp_q[k].data)) begin
        bad++;
        $display("FAIL %s mem_txn[%0d]: got we=%0b addr=%h data=%h want we=%0b addr=%h data=%h",
                 nm, k, log_q[k].we, log_q[k].addr, log_q[k].data,
                 exp_q[k].we, exp_q[k].addr, exp_q[k].data);
      end
    end

    if (miss) begin
      m_valid[ix] = 1; m_tag[ix] = tg; m_dirty[ix] = 0;
    end
    if (wr) begin
      arch[wa] = merge(arch_val(wa), d, s);
      m_dirty[ix] = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1; rd_en = 0; wr_en = 0; addr = 0; wdata = 0; wstrb = 0; max_gap = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem: got req=%0b we=%0b addr=%h wdata=%h want all zero",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    total++;
    if (dcache_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall: got %0b want 0", dcache_stall);
    end
  endtask

  task automatic test_refill();
    max_gap = 0;
    do_access(1, 0, 32'h40, 0, 4'h0, "refill_load");
    do_access(1, 0, 32'h48, 0, 4'h0, "refill_hit");
  endtask

  task automatic test_store_hit();
    max_gap = 0;
    do_access(0, 1, 32'h44, 32'hDEAD_BEEF, 4'b0011, "store_hit");
    total++;
    if (arch_val(32'h44) !== 32'h0000_BEEF) begin
      bad++;
      $display("FAIL store_merge_model: got %h want 0000beef", arch_val(32'h44));
    end
    do_access(1, 0, 32'h44, 0, 4'h0, "store_hit_load");
  endtask

  task automatic test_dirty_evict();
    max_gap = 0;
    do_access(1, 0, 32'h440, 0, 4'h0, "dirty_evict");
  endtask

  task automatic test_rd_wr_both();
    max_gap = 0;
    do_access(1, 1, 32'h444, $urandom, 4'hF, "rdwr_store");
    do_access(1, 0, 32'h444, 0, 4'h0, "rdwr_load");
    do_access(1, 0, 32'h40, 0, 4'h0, "rdwr_evict");
  endtask

  task automatic test_store_miss_gaps();
    max_gap = 3;
    do_access(0, 1, 32'h800, $urandom, 4'($urandom_range(1, 15)), "store_miss");
    do_access(1, 0, 32'h800, 0, 4'h0, "store_miss_load");
    do_access(1, 0, 32'h1800, 0, 4'h0, "store_miss_evict");
  endtask

  task automatic test_reset_mid_refill();
    int acks, n;
    max_gap = 0; acks = 0; n = 0;
    @(negedge clk);
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    rd_en = 1; wr_en = 0; addr = 32'h40;
    while (acks < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
      if (mem_ack === 1'b1 && mem_we === 1'b0) acks++;
    end
    total++;
    if (acks != 2) begin
      bad++;
      $display("FAIL midreset_acks: got %0d want 2", acks);
    end
    rst = 1;
    @(posedge clk); #1;
    rd_en = 0;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || dcache_stall !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: got req=%0b addr=%h stall=%0b want 0 0 0",
               mem_req, mem_addr, dcache_stall);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    do_access(1, 0, 32'h40, 0, 4'h0, "midreset_reload");
  endtask

  task automatic test_random();
    for (int i = 0; i < 250; i++) begin
      int unsigned tg, ix, w, a;
      int k;
      tg = $urandom_range(0, 3);
      ix = $urandom_range(0, 3);
      w  = $urandom_range(0, 3);
      k  = $urandom_range(0, 2);
      max_gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      a = (tg << 10) | (ix << 4) | (w << 2) | $urandom_range(0, 3);
      do_access(k != 1, k != 0, a, $urandom, 4'($urandom), "random");
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; max_gap = 0;
    rst = 1; rd_en = 0; wr_en = 0; addr = 0; wdata = 0; wstrb = 0;
    bmem[32'h40] = 32'h11;
    bmem[32'h44] = 32'h22;
    bmem[32'h48] = 32'h33;
    bmem[32'h4C] = 32'h44;
    test_reset();
    test_refill();
    test_store_hit();
    test_dirty_evict();
    test_rd_wr_both();
    test_store_miss_gaps();
    test_reset_mid_refill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
